// File: rtl/blink_pkg.sv
// Shared types and constants for the setting-mode blink scheduler.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        HOLD = 2'd3
    } blink_state_t;

    localparam logic [1:0] MODE_CLOCK = 2'd0;
    localparam logic [1:0] MODE_TSET  = 2'd1;
    localparam logic [1:0] MODE_ASET  = 2'd2;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;
    localparam logic [1:0] POS_NONE = 2'd3;

    function automatic logic [5:0] pos2mask(input logic [1:0] pos);
        logic [5:0] m;
        m = '0;
        case (pos)
            POS_SEC:  m = 6'b000011;
            POS_MIN:  m = 6'b001100;
            POS_HOUR: m = 6'b110000;
            default:  m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/blink_idle_timer.sv
// Idle counter for the blink scheduler; hit marks the last idle cycle before timeout.
module blink_idle_timer #(
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned CNT_W         = 8
) (
    input  logic blink_on_clk,
    input  logic rst_n,
    input  logic run,
    output logic hit
);

    logic [CNT_W-1:0] idle_cnt;

    assign hit = run && (idle_cnt == CNT_W'(TIMEOUT_TICKS - 1));

    always_ff @(posedge blink_on_clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (!run || hit) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/blink_sched.sv
// Blink scheduler for clock-display setting modes; BLINK_TIMEOUT_EN enables the idle timeout and HOLD state.
module blink_sched
    import blink_pkg::*;
#(
    parameter int unsigned ON_TICKS      = 1,
    parameter int unsigned OFF_TICKS     = 1,
    parameter int unsigned TIMEOUT_TICKS = 30,
    parameter int unsigned CNT_W         = 8
) (
    input  logic       blink_on_clk,
    input  logic       rst_n,
    input  logic [1:0] setting_mode,
    input  logic [1:0] setting_position,
    input  logic       i_activity,
    output logic       o_blink,
    output logic [5:0] o_blank_mask,
    output logic       o_timeout
);

    blink_state_t     state;
    logic [CNT_W-1:0] phase_cnt;
    logic [1:0]       prev_pos;
    logic [1:0]       prev_mode;
    logic             active;
    logic             running;
    logic             restart;
    logic             on_end;
    logic             off_end;
    logic             idle_hit;

    assign active  = (setting_mode == MODE_TSET) || (setting_mode == MODE_ASET);
    assign running = (state == ON) || (state == OFF);
    // While running, prev_mode is always an active mode, so any mode change is a 1<->2 switch.
    assign restart = running && (i_activity || (setting_position != prev_pos)
                                 || (setting_mode != prev_mode));
    assign on_end  = (phase_cnt == CNT_W'(ON_TICKS - 1));
    assign off_end = (phase_cnt == CNT_W'(OFF_TICKS - 1));

`ifdef BLINK_TIMEOUT_EN
    blink_idle_timer #(
        .TIMEOUT_TICKS(TIMEOUT_TICKS),
        .CNT_W        (CNT_W)
    ) u_idle_timer (
        .blink_on_clk(blink_on_clk),
        .rst_n       (rst_n),
        .run         (active && running && !restart),
        .hit         (idle_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_TICKS;
    assign idle_hit           = 1'b0;
`endif

    always_ff @(posedge blink_on_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            phase_cnt    <= '0;
            prev_pos     <= '0;
            prev_mode    <= '0;
            o_blink      <= 1'b0;
            o_blank_mask <= '0;
            o_timeout    <= 1'b0;
        end else begin
            prev_pos  <= setting_position;
            prev_mode <= setting_mode;
            o_timeout <= 1'b0;
            // Priority: exit, then entry/restart, then timeout, then phase progression.
            if (!active) begin
                state        <= IDLE;
                phase_cnt    <= '0;
                o_blink      <= 1'b0;
                o_blank_mask <= '0;
            end else if ((state == IDLE) || restart) begin
                state        <= ON;
                phase_cnt    <= '0;
                o_blink      <= 1'b1;
                o_blank_mask <= '0;
            end else if (idle_hit) begin
                state        <= HOLD;
                phase_cnt    <= '0;
                o_timeout    <= 1'b1;
                o_blink      <= 1'b1;
                o_blank_mask <= '0;
            end else begin
                case (state)
                    ON: begin
                        if (on_end) begin
                            state        <= OFF;
                            phase_cnt    <= '0;
                            o_blink      <= 1'b0;
                            o_blank_mask <= pos2mask(setting_position);
                        end else begin
                            phase_cnt    <= phase_cnt + 1'b1;
                            o_blink      <= 1'b1;
                            o_blank_mask <= '0;
                        end
                    end
                    OFF: begin
                        if (off_end) begin
                            state        <= ON;
                            phase_cnt    <= '0;
                            o_blink      <= 1'b1;
                            o_blank_mask <= '0;
                        end else begin
                            phase_cnt    <= phase_cnt + 1'b1;
                            o_blink      <= 1'b0;
                            o_blank_mask <= pos2mask(setting_position);
                        end
                    end
                    default: begin
                        state        <= HOLD;
                        phase_cnt    <= '0;
                        o_blink      <= 1'b1;
                        o_blank_mask <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_blink_sched.sv
// Directed bench for blink_sched; three instances cover default timing, 2/3 timing and a short timeout.
module tb_blink_sched;

    logic       clk;
    logic       rst_n;

    logic [1:0] mode_a, pos_a, mode_b, pos_b, mode_c, pos_c;
    logic       act_a, act_b, act_c;
    logic       blink_a, blink_b, blink_c;
    logic [5:0] mask_a, mask_b, mask_c;
    logic       to_a, to_b, to_c;

    int tests;
    int fails;

    blink_sched #(
        .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(200), .CNT_W(8)
    ) dut_a (
        .blink_on_clk(clk), .rst_n(rst_n), .setting_mode(mode_a),
        .setting_position(pos_a), .i_activity(act_a),
        .o_blink(blink_a), .o_blank_mask(mask_a), .o_timeout(to_a)
    );

    blink_sched #(
        .ON_TICKS(2), .OFF_TICKS(3), .TIMEOUT_TICKS(200), .CNT_W(8)
    ) dut_b (
        .blink_on_clk(clk), .rst_n(rst_n), .setting_mode(mode_b),
        .setting_position(pos_b), .i_activity(act_b),
        .o_blink(blink_b), .o_blank_mask(mask_b), .o_timeout(to_b)
    );

    blink_sched #(
        .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(5), .CNT_W(8)
    ) dut_c (
        .blink_on_clk(clk), .rst_n(rst_n), .setting_mode(mode_c),
        .setting_position(pos_c), .i_activity(act_c),
        .o_blink(blink_c), .o_blank_mask(mask_c), .o_timeout(to_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [1:0] m, input logic [1:0] p);
        rst_n  = 1'b0;
        mode_a = m; pos_a = p; act_a = 1'b0;
        mode_b = m; pos_b = p; act_b = 1'b0;
        mode_c = m; pos_c = p; act_c = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset(2'd1, 2'd1);
        rst_n = 1'b0;
        #2;
        tests++;
        if (blink_a !== 1'b0) begin
            fails++; $display("FAIL reset_blink: got %b expected 0", blink_a);
        end
        tests++;
        if (mask_a !== 6'b000000) begin
            fails++; $display("FAIL reset_mask: got %b expected 000000", mask_a);
        end
        tests++;
        if (to_a !== 1'b0) begin
            fails++; $display("FAIL reset_timeout: got %b expected 0", to_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        tests++;
        if (blink_a !== 1'b1 || mask_a !== 6'b000000) begin
            fails++; $display("FAIL reset_first_cycle: got blink=%b mask=%b expected 1/000000", blink_a, mask_a);
        end
    endtask

    task automatic test_alternate();
        logic       eb;
        logic [5:0] em;
        apply_reset(2'd1, 2'd1);
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            eb = (i % 2 == 1);
            em = eb ? 6'b000000 : 6'b001100;
            tests++;
            if (blink_a !== eb || mask_a !== em) begin
                fails++; $display("FAIL alternate[%0d]: got blink=%b mask=%b expected %b/%b", i, blink_a, mask_a, eb, em);
            end
        end
    endtask

    task automatic test_pattern();
        logic       eb;
        logic [5:0] em;
        apply_reset(2'd1, 2'd2);
        for (int k = 0; k < 10; k++) begin
            tick();
            eb = ((k % 5) < 2);
            em = eb ? 6'b000000 : 6'b110000;
            tests++;
            if (blink_b !== eb || mask_b !== em) begin
                fails++; $display("FAIL pattern[%0d]: got blink=%b mask=%b expected %b/%b", k, blink_b, mask_b, eb, em);
            end
        end
    endtask

    task automatic test_restart();
        apply_reset(2'd1, 2'd2);
        tick(); tick(); tick();
        act_b = 1'b1;
        tick();
        act_b = 1'b0;
        tests++;
        if (blink_b !== 1'b1) begin
            fails++; $display("FAIL restart_act_on: got %b expected 1", blink_b);
        end
        tick();
        tests++;
        if (blink_b !== 1'b1) begin
            fails++; $display("FAIL restart_act_full_on: got %b expected 1", blink_b);
        end
        tick();
        tests++;
        if (blink_b !== 1'b0 || mask_b !== 6'b110000) begin
            fails++; $display("FAIL restart_act_off: got blink=%b mask=%b expected 0/110000", blink_b, mask_b);
        end

        apply_reset(2'd1, 2'd0);
        tick(); tick();
        tests++;
        if (blink_a !== 1'b0 || mask_a !== 6'b000011) begin
            fails++; $display("FAIL restart_pos_off0: got blink=%b mask=%b expected 0/000011", blink_a, mask_a);
        end
        pos_a = 2'd1;
        tick();
        tests++;
        if (blink_a !== 1'b1 || mask_a !== 6'b000000) begin
            fails++; $display("FAIL restart_pos_on: got blink=%b mask=%b expected 1/000000", blink_a, mask_a);
        end
        tick();
        tests++;
        if (blink_a !== 1'b0 || mask_a !== 6'b001100) begin
            fails++; $display("FAIL restart_pos_off1: got blink=%b mask=%b expected 0/001100", blink_a, mask_a);
        end
    endtask

    task automatic test_mode_switch();
        apply_reset(2'd1, 2'd0);
        tick(); tick(); tick();
        mode_b = 2'd2;
        tick();
        tests++;
        if (blink_b !== 1'b1) begin
            fails++; $display("FAIL mode_switch_on: got %b expected 1", blink_b);
        end
        tick();
        tests++;
        if (blink_b !== 1'b1) begin
            fails++; $display("FAIL mode_switch_on2: got %b expected 1", blink_b);
        end
        tick();
        tests++;
        if (blink_b !== 1'b0 || mask_b !== 6'b000011) begin
            fails++; $display("FAIL mode_switch_off: got blink=%b mask=%b expected 0/000011", blink_b, mask_b);
        end
    endtask

    task automatic test_exit();
        apply_reset(2'd1, 2'd1);
        tick(); tick();
        mode_a = 2'd0;
        act_a  = 1'b1;
        tick();
        act_a = 1'b0;
        tests++;
        if (blink_a !== 1'b0 || mask_a !== 6'b000000) begin
            fails++; $display("FAIL exit_idle: got blink=%b mask=%b expected 0/000000", blink_a, mask_a);
        end
        tick();
        tests++;
        if (blink_a !== 1'b0) begin
            fails++; $display("FAIL exit_stay_idle: got %b expected 0", blink_a);
        end

        apply_reset(2'd1, 2'd1);
        tick();
        mode_a = 2'd3;
        tick();
        tests++;
        if (blink_a !== 1'b0 || mask_a !== 6'b000000) begin
            fails++; $display("FAIL exit_mode3: got blink=%b mask=%b expected 0/000000", blink_a, mask_a);
        end

        apply_reset(2'd2, 2'd3);
        tick(); tick();
        tests++;
        if (blink_a !== 1'b0 || mask_a !== 6'b000000) begin
            fails++; $display("FAIL pos_none_off: got blink=%b mask=%b expected 0/000000", blink_a, mask_a);
        end
    endtask

    task automatic test_timeout();
        logic       eb;
        logic       et;
        logic [5:0] em;
        apply_reset(2'd1, 2'd1);
`ifdef BLINK_TIMEOUT_EN
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) act_c = 1'b1;
            tick();
            act_c = 1'b0;
            et = (k == 6);
            if (k >= 6) begin
                eb = 1'b1; em = 6'b000000;
            end else begin
                eb = (k % 2 == 1);
                em = eb ? 6'b000000 : 6'b001100;
            end
            tests++;
            if (to_c !== et || blink_c !== eb || mask_c !== em) begin
                fails++; $display("FAIL timeout[%0d]: got to=%b blink=%b mask=%b expected %b/%b/%b", k, to_c, blink_c, mask_c, et, eb, em);
            end
        end
        mode_c = 2'd0;
        tick();
        tests++;
        if (blink_c !== 1'b0 || to_c !== 1'b0) begin
            fails++; $display("FAIL timeout_exit: got blink=%b to=%b expected 0/0", blink_c, to_c);
        end
`else
        for (int k = 1; k <= 40; k++) begin
            tick();
            tests++;
            if (to_c !== 1'b0) begin
                fails++; $display("FAIL no_timeout[%0d]: got %b expected 0", k, to_c);
            end
        end
`endif
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_alternate();
        test_pattern();
        test_restart();
        test_mode_switch();
        test_exit();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
